// File: rtl/fix_trailer_gen_pkg.sv
// Shared FIX trailer definitions: ASCII constants, trailer state encoding,
// and the digit-to-ASCII helper. Also used by the RX checksum checker.
package fix_trailer_gen_pkg;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_1     = 8'h31;
  localparam logic [7:0] ASCII_EQ    = 8'h3D;
  localparam logic [7:0] SOH         = 8'h01;
  localparam int         TRAILER_LEN = 7;

  // S_BODY passes the message through; the rest emit "10=DDD<SOH>" in order.
  typedef enum logic [2:0] {
    S_BODY,
    S_T1,
    S_T0,
    S_EQ,
    S_D2,
    S_D1,
    S_D0,
    S_SOH
  } trailer_state_e;

  // A BCD digit becomes its ASCII character by OR-ing in '0'.
  function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
    return ASCII_0 | {4'h0, d};
  endfunction

endpackage

// File: rtl/fix_trailer_gen_if.sv
// Byte-stream bundle around the trailer generator: body stream in (s_*),
// body+trailer stream out (m_*). slave = generator side, master = environment.
interface fix_trailer_gen_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready;

  modport slave (
    input  s_data, s_valid, s_last, m_ready,
    output s_ready, m_data, m_valid, m_last
  );

  modport master (
    output s_data, s_valid, s_last, m_ready,
    input  s_ready, m_data, m_valid, m_last
  );
endinterface

// File: rtl/fix_trailer_gen_bin2bcd.sv
// Combinational 8-bit binary to three BCD digits (shift-and-add-3).
module fix_trailer_gen_bin2bcd (
  input  logic [7:0] i_bin,
  output logic [3:0] o_hund,
  output logic [3:0] o_tens,
  output logic [3:0] o_unit
);

  logic [11:0] w_bcd;

  // Adjust any digit >= 5 before each shift so it carries correctly in decimal.
  always_comb begin
    w_bcd = 12'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_bcd[3:0]  >= 4'd5) w_bcd[3:0]  = w_bcd[3:0]  + 4'd3;
      if (w_bcd[7:4]  >= 4'd5) w_bcd[7:4]  = w_bcd[7:4]  + 4'd3;
      if (w_bcd[11:8] >= 4'd5) w_bcd[11:8] = w_bcd[11:8] + 4'd3;
      w_bcd = {w_bcd[10:0], i_bin[3'(i)]};
    end
  end

  assign o_hund = w_bcd[11:8];
  assign o_tens = w_bcd[7:4];
  assign o_unit = w_bcd[3:0];

endmodule

// File: rtl/fix_trailer_gen.sv
// TX FIX trailer generator: forwards body bytes through one output register,
// sums them mod 256, and appends "10=DDD<SOH>" after the s_last byte.
module fix_trailer_gen
  import fix_trailer_gen_pkg::*;
#(
  parameter int         DATA_WIDTH = 8,
  parameter logic [7:0] SOH_CHAR   = SOH
) (
  input  logic                clk,
  input  logic                rst_n,
  fix_trailer_gen_if.slave    bus,
  output logic                busy,
  output logic [7:0]          checksum,
  output logic                checksum_valid
);

  trailer_state_e         r_state;
  trailer_state_e         w_state_next;
  logic [DATA_WIDTH-1:0]  r_m_data;
  logic                   r_m_valid;
  logic                   r_m_last;
  logic [7:0]             r_sum;
  logic [7:0]             r_checksum;
  logic                   r_checksum_valid;
  logic                   w_free;
  logic                   w_s_ready;
  logic                   w_accept;
  logic                   w_load;
  logic                   w_load_last;
  logic [DATA_WIDTH-1:0]  w_load_data;
  logic [3:0]             w_hund;
  logic [3:0]             w_tens;
  logic [3:0]             w_unit;

  // Output register can take a new byte when empty or being drained this cycle.
  assign w_free = !r_m_valid || bus.m_ready;

  // Digits come from the registered checksum, stable for the whole trailer.
  fix_trailer_gen_bin2bcd u_bin2bcd (
    .i_bin  (r_checksum),
    .o_hund (w_hund),
    .o_tens (w_tens),
    .o_unit (w_unit)
  );

  // State register; reset mid-trailer drops the rest of the trailer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_BODY;
    else        r_state <= w_state_next;
  end

  // Next state: body until s_last is taken, then one trailer state per loaded beat.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_BODY:  if (w_accept && bus.s_last) w_state_next = S_T1;
      S_SOH:   if (w_free) w_state_next = S_BODY;
      default: if (w_free) w_state_next = trailer_state_e'(r_state + 3'd1);
    endcase
  end

  // Output decode: what the output register loads this cycle and handshake.
  always_comb begin
    w_s_ready   = 1'b0;
    w_accept    = 1'b0;
    w_load      = w_free;
    w_load_data = '0;
    w_load_last = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_BODY: begin
        busy        = 1'b0;
        w_s_ready   = w_free && rst_n;
        w_accept    = bus.s_valid && w_s_ready;
        w_load      = w_accept;
        w_load_data = bus.s_data;
      end
      S_T1:  w_load_data = ASCII_1;
      S_T0:  w_load_data = ASCII_0;
      S_EQ:  w_load_data = ASCII_EQ;
      S_D2:  w_load_data = digit_to_ascii(w_hund);
      S_D1:  w_load_data = digit_to_ascii(w_tens);
      S_D0:  w_load_data = digit_to_ascii(w_unit);
      default: begin
        w_load_data = SOH_CHAR;
        w_load_last = 1'b1;
      end
    endcase
  end

  // Output stage: load when decoded, drop valid once drained, hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end else if (w_load) begin
      r_m_data  <= w_load_data;
      r_m_valid <= 1'b1;
      r_m_last  <= w_load_last;
    end else if (bus.m_ready) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end
  end

  // Running sum; the s_last byte closes the body and publishes the checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum            <= 8'd0;
      r_checksum       <= 8'd0;
      r_checksum_valid <= 1'b0;
    end else begin
      r_checksum_valid <= 1'b0;
      if (w_accept) begin
        if (bus.s_last) begin
          r_checksum       <= r_sum + bus.s_data;
          r_checksum_valid <= 1'b1;
          r_sum            <= 8'd0;
        end else begin
          r_sum <= r_sum + bus.s_data;
        end
      end
    end
  end

  assign bus.s_ready    = w_s_ready;
  assign bus.m_data     = r_m_data;
  assign bus.m_valid    = r_m_valid;
  assign bus.m_last     = r_m_last;
  assign checksum       = r_checksum;
  assign checksum_valid = r_checksum_valid;

endmodule

// File: tb/tb_fix_trailer_gen.sv
// Scoreboard bench for fix_trailer_gen: the driver pushes expected output
// bytes and checksums from a byte-level model; a monitor pops and compares.
module tb_fix_trailer_gen;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [7:0] checksum;
  logic       checksum_valid;

  always #5 clk = ~clk;

  fix_trailer_gen_if bus();

  fix_trailer_gen dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus.slave),
    .busy           (busy),
    .checksum       (checksum),
    .checksum_valid (checksum_valid)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [8:0] exp_q[$];
  logic [7:0] cs_q[$];
  int         model_sum = 0;
  int         rdy_mode  = 1;
  bit         eq_armed  = 1'b0;
  bit         eq_seen   = 1'b0;
  bit         stall_pending = 1'b0;
  logic [8:0] stall_held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: body bytes pass through; after the last byte the trailer is
  // "10=" + three decimal digits of (sum mod 256) + SOH, with m_last on SOH.
  task automatic model_accept(input logic [7:0] b, input bit last);
    int cs;
    model_sum = (model_sum + int'(b)) % 256;
    exp_q.push_back({1'b0, b});
    if (last) begin
      cs = model_sum;
      exp_q.push_back({1'b0, 8'h31});
      exp_q.push_back({1'b0, 8'h30});
      exp_q.push_back({1'b0, 8'h3D});
      exp_q.push_back({1'b0, 8'(48 + cs / 100)});
      exp_q.push_back({1'b0, 8'(48 + (cs / 10) % 10)});
      exp_q.push_back({1'b0, 8'(48 + cs % 10)});
      exp_q.push_back({1'b1, 8'h01});
      cs_q.push_back(8'(cs));
      model_sum = 0;
    end
  endtask

  // Downstream ready: always 1, or a coin flip each cycle.
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.m_ready = (rdy_mode == 1) ? 1'b1 : ($urandom_range(0, 1) == 1);
    end
  end

  // Monitor: transfers and stalls are judged at the falling edge.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_pending = 1'b0;
      end else begin
        if (stall_pending)
          check("stall_hold", {23'd0, bus.m_valid, bus.m_last, bus.m_data}, {23'd0, 1'b1, stall_held});
        stall_pending = 1'b0;
        if (bus.m_valid && !bus.m_ready) begin
          stall_pending = 1'b1;
          stall_held    = {bus.m_last, bus.m_data};
        end
        if (bus.m_valid && bus.m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL out_extra actual=%0h expected=none", {bus.m_last, bus.m_data});
          end else begin
            e = exp_q.pop_front();
            check("out_byte", {23'd0, bus.m_last, bus.m_data}, {23'd0, e});
            $display("out data=%02h last=%0d exp=%02h/%0d", bus.m_data, bus.m_last, e[7:0], e[8]);
            if (eq_armed && e == 9'h03D) eq_seen = 1'b1;
          end
        end
        if (checksum_valid) begin
          if (cs_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL cs_extra actual=%02h expected=none", checksum);
          end else begin
            e = {1'b0, cs_q.pop_front()};
            check("checksum", {24'd0, checksum}, {24'd0, e[7:0]});
            $display("checksum=%02h exp=%02h", checksum, e[7:0]);
          end
        end
      end
    end
  end

  // Offer one byte, wait (bounded) for acceptance, return the stall count.
  task automatic send_byte(input logic [7:0] b, input bit last, input int gap, output int waits);
    bit done;
    bus.s_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    bus.s_last  = last;
    waits = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (bus.s_ready) begin
        model_accept(b, last);
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 300) begin
          checks++;
          failures++;
          $display("FAIL accept_timeout actual=%0d expected<=300", waits);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic send_msg(input logic [7:0] bytes[$], input int maxgap);
    int w;
    for (int i = 0; i < bytes.size(); i++)
      send_byte(bytes[i], i == bytes.size() - 1, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0, w);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d expected=0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] msg[$];
    int         w;
    int         n;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;

    // Reset values while held in reset.
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    check("rst_m_last", {31'd0, bus.m_last}, 32'd0);
    check("rst_m_data", {24'd0, bus.m_data}, 32'd0);
    check("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_checksum", {24'd0, checksum}, 32'd0);
    check("rst_cs_valid", {31'd0, checksum_valid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed messages with fixed downstream ready.
    msg = '{8'h41, 8'h42, 8'h01};
    send_msg(msg, 0);
    wait_drain();
    check("t1_checksum", {24'd0, checksum}, 32'h84);
    msg = '{8'hFF, 8'hFF, 8'h03};
    send_msg(msg, 0);
    wait_drain();
    check("t2_checksum", {24'd0, checksum}, 32'h01);
    msg = '{8'hFE, 8'h01};
    send_msg(msg, 0);
    wait_drain();
    check("t3_checksum", {24'd0, checksum}, 32'hFF);

    // Same message under random backpressure.
    rdy_mode = 0;
    msg = '{8'h41, 8'h42, 8'h01};
    send_msg(msg, 0);
    wait_drain();
    rdy_mode = 1;

    // Back-to-back: s_valid held across the trailer of message A.
    send_byte(8'h41, 1'b0, 0, w);
    send_byte(8'h42, 1'b0, 0, w);
    send_byte(8'h01, 1'b1, 0, w);
    send_byte(8'h01, 1'b1, 0, w);
    check("b2b_stall", w, 32'd7);
    wait_drain();
    check("b2b_checksum", {24'd0, checksum}, 32'h01);

    // Reset right after the '=' beat leaves the port.
    eq_armed = 1'b1;
    eq_seen  = 1'b0;
    msg = '{8'h41, 8'h42, 8'h01};
    send_msg(msg, 0);
    n = 0;
    while (!eq_seen && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (!eq_seen) begin
      checks++;
      failures++;
      $display("FAIL eq_timeout actual=0 expected=1");
    end
    #1;
    rst_n = 1'b0;
    eq_armed = 1'b0;
    exp_q.delete();
    model_sum = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst6_m_valid", {31'd0, bus.m_valid}, 32'd0);
    check("rst6_busy", {31'd0, busy}, 32'd0);
    check("rst6_checksum", {24'd0, checksum}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    msg = '{8'h05};
    send_msg(msg, 0);
    wait_drain();
    check("t6_checksum", {24'd0, checksum}, 32'h05);

    // Random messages, random lengths, gaps and backpressure.
    for (int m = 0; m < 25; m++) begin
      msg.delete();
      n = int'($urandom_range(1, 20));
      for (int i = 0; i < n; i++) msg.push_back(8'($urandom_range(0, 255)));
      rdy_mode = int'($urandom_range(0, 1));
      send_msg(msg, 2);
    end
    rdy_mode = 1;
    wait_drain();

    check("end_exp_empty", exp_q.size(), 32'd0);
    check("end_cs_empty", cs_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
